// File: rtl/dma_types_pkg.sv
// State encoding shared by the OAM DMA engine and anything that observes it.
package dma_types_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_t;

endpackage

// File: rtl/mmu_addresses_pkg.sv
// Memory-map constants shared by the MMU, PPU and DMA blocks.
package mmu_addresses_pkg;

    localparam logic [15:0] DMA_OAM_addr = 16'hFF46;
    localparam logic [15:0] OAM_start    = 16'hFE00;
    localparam int          OAM_len      = 160;

endpackage

// File: rtl/oam_dma_engine_if.sv
// Bundle of CPU register bus, MMU source-read port and PPU OAM write port seen by the DMA engine.
interface oam_dma_engine_if;

    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_rdata;

    logic        src_read_req;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;

    logic        oam_write_en;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    logic        dma_active;

    modport master (
        input  bus_addr,
        input  bus_wdata,
        input  bus_write_en,
        input  bus_read_en,
        output bus_rdata,
        output src_read_req,
        output src_addr,
        input  src_rdata,
        output oam_write_en,
        output oam_addr,
        output oam_wdata,
        output dma_active
    );

    modport slave (
        output bus_addr,
        output bus_wdata,
        output bus_write_en,
        output bus_read_en,
        input  bus_rdata,
        input  src_read_req,
        input  src_addr,
        output src_rdata,
        input  oam_write_en,
        input  oam_addr,
        input  oam_wdata,
        input  dma_active
    );

endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA initiator: register 0xFF46 starts a copy of one source page into OAM, one byte per M-cycle.
// Optional OAM_DMA_ECHO_REMAP_EN folds source pages E0-FF onto C0-DF (echo RAM -> WRAM).
module oam_dma_engine
    import mmu_addresses_pkg::*;
    import dma_types_pkg::*;
#(
    parameter int XFER_BYTES      = OAM_len,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic                clk,
    input  logic                reset,
    oam_dma_engine_if.master    dma
);

    localparam int PW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [1:0] ST_IDLE  = DMA_IDLE;
    localparam logic [1:0] ST_START = DMA_START;
    localparam logic [1:0] ST_XFER  = DMA_XFER;

    logic [1:0]    r_state;
    logic [7:0]    r_page;
    logic [7:0]    r_byte_idx;
    logic [PW-1:0] r_phase;
    logic [DW-1:0] r_delay;
    logic [7:0]    r_data;

    logic w_reg_write;
    logic w_delay_done;
    logic w_phase_last;
    logic w_byte_last;
    logic w_src_req;
    logic w_oam_we;

    function automatic logic [7:0] page_remap(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
        return page;
`endif
    endfunction

    assign w_reg_write  = dma.bus_write_en && (dma.bus_addr == DMA_OAM_addr);
    assign w_delay_done = (r_delay == DW'(START_DELAY - 1));
    assign w_phase_last = (r_phase == PW'(CYCLES_PER_BYTE - 1));
    assign w_byte_last  = (r_byte_idx == 8'(XFER_BYTES - 1));
    assign w_src_req    = (r_state == ST_XFER) && (r_phase == '0);
    assign w_oam_we     = (r_state == ST_XFER) && (r_phase == PW'(1));

    // A register write takes priority over every state, so a restart has no dead cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_page     <= 8'h00;
            r_byte_idx <= 8'h00;
            r_phase    <= '0;
            r_delay    <= '0;
            r_data     <= 8'h00;
        end else begin
            if (w_reg_write) begin
                r_page     <= dma.bus_wdata;
                r_state    <= ST_START;
                r_byte_idx <= 8'h00;
                r_phase    <= '0;
                r_delay    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_START: begin
                        if (w_delay_done) begin
                            r_state <= ST_XFER;
                            r_delay <= '0;
                        end else begin
                            r_delay <= r_delay + DW'(1);
                        end
                    end
                    ST_XFER: begin
                        if (w_phase_last) begin
                            r_phase <= '0;
                            if (w_byte_last) begin
                                r_state    <= ST_IDLE;
                                r_byte_idx <= 8'h00;
                            end else begin
                                r_byte_idx <= r_byte_idx + 8'd1;
                            end
                        end else begin
                            r_phase <= r_phase + PW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end

            // Source data is captured on the read edge regardless of a coincident restart.
            if (w_src_req) begin
                r_data <= dma.src_rdata;
            end
        end
    end

    assign dma.bus_rdata    = (dma.bus_read_en && (dma.bus_addr == DMA_OAM_addr)) ? r_page : 8'hFF;
    assign dma.src_read_req = w_src_req;
    assign dma.src_addr     = {page_remap(r_page), r_byte_idx};
    assign dma.oam_write_en = w_oam_we;
    assign dma.oam_addr     = r_byte_idx;
    assign dma.oam_wdata    = r_data;
    assign dma.dma_active   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: expected source reads and OAM writes are queued per transfer.
module tb_oam_dma_engine;

    logic clk;
    logic reset_n;

    oam_dma_engine_if dif ();

    oam_dma_engine #(
        .XFER_BYTES      (160),
        .CYCLES_PER_BYTE (4),
        .START_DELAY     (4)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .dma   (dif)
    );

    assign dif.src_rdata = dif.src_addr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int pulse_cnt;
    logic [15:0] exp_src[$];
    logic [15:0] exp_oam[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_REMAP_EN
        if (page >= 8'hE0) return page - 8'h20;
`endif
        return page;
    endfunction

    task automatic push_expect(input logic [7:0] page);
        for (int i = 0; i < 160; i++) begin
            logic [7:0] idx;
            idx = 8'(i);
            exp_src.push_back({exp_page(page), idx});
            exp_oam.push_back({idx, idx ^ 8'h5A});
        end
    endtask

    task automatic flush_expect();
        exp_src.delete();
        exp_oam.delete();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        dif.bus_addr     = addr;
        dif.bus_wdata    = data;
        dif.bus_write_en = 1'b1;
        @(posedge clk);
        #1;
        dif.bus_write_en = 1'b0;
    endtask

    task automatic bus_read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        @(negedge clk);
        dif.bus_addr    = addr;
        dif.bus_read_en = 1'b1;
        #1;
        check(tag, 32'(dif.bus_rdata), 32'(exp));
        $display("bus read  addr=%h data=%h", addr, dif.bus_rdata);
        dif.bus_read_en = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every source read and OAM write, checks pulse shape.
    initial begin
        logic prev_we;
        logic have_last;
        int   gap;
        logic [15:0] e;
        prev_we   = 1'b0;
        have_last = 1'b0;
        gap       = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_we   = 1'b0;
                have_last = 1'b0;
                gap       = 0;
            end else begin
                gap++;
                if (dif.src_read_req) begin
                    if (exp_src.size() > 0) begin
                        e = exp_src.pop_front();
                        check("src_addr", 32'(dif.src_addr), 32'(e));
                    end else begin
                        check("src_unexpected", 32'(dif.src_addr), 32'hFFFF_FFFF);
                    end
                end
                if (dif.oam_write_en) begin
                    if (exp_oam.size() > 0) begin
                        e = exp_oam.pop_front();
                        check("oam_addr", 32'(dif.oam_addr), 32'(e[15:8]));
                        check("oam_wdata", 32'(dif.oam_wdata), 32'(e[7:0]));
                    end else begin
                        check("oam_unexpected", 32'(dif.oam_addr), 32'hFFFF_FFFF);
                    end
                    $display("oam write addr=%h data=%h", dif.oam_addr, dif.oam_wdata);
                    check("we_width", 32'(prev_we), 32'd0);
                    if (have_last) check("we_gap_ge4", 32'(gap >= 4), 32'd1);
                    pulse_cnt++;
                    have_last = 1'b1;
                    gap       = 0;
                end
                if (!dif.dma_active) begin
                    check("we_idle", 32'(dif.oam_write_en), 32'd0);
                    check("src_idle", 32'(dif.src_read_req), 32'd0);
                end
                prev_we = dif.oam_write_en;
            end
        end
    end

    // One transfer, optionally restarted with page2 two cycles after the write of byte restart_after.
    task automatic run_xfer(input logic [7:0] page, input int restart_after,
                            input logic [7:0] page2, input int exp_active);
        int  n;
        int  act;
        int  first;
        int  cd;
        logic restarted;
        n = 0; act = 0; first = 0; cd = 0; restarted = 1'b0;
        pulse_cnt = 0;
        push_expect(page);
        bus_write(16'hFF46, page);
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (dif.oam_write_en && first == 0) first = n;
            if (!dif.dma_active) break;
            act++;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dif.bus_addr     = 16'hFF46;
                    dif.bus_wdata    = page2;
                    dif.bus_write_en = 1'b1;
                    @(posedge clk);
                    #1;
                    dif.bus_write_en = 1'b0;
                    check("pre_restart_pulses", 32'(pulse_cnt), 32'(restart_after + 1));
                    pulse_cnt = 0;
                    flush_expect();
                    push_expect(page2);
                    restarted = 1'b1;
                end
            end else if (restart_after >= 0 && !restarted && dif.oam_write_en &&
                         int'(dif.oam_addr) == restart_after) begin
                cd = 2;
            end
        end
        check("first_we_clk", 32'(first), 32'd6);
        check("active_clks", 32'(act), 32'(exp_active));
        check("pulses", 32'(pulse_cnt), 32'd160);
        check("src_q_empty", 32'(exp_src.size()), 32'd0);
        check("oam_q_empty", 32'(exp_oam.size()), 32'd0);
        $display("xfer page=%h restart_after=%0d active=%0d pulses=%0d", page, restart_after, act, pulse_cnt);
    endtask

    initial begin
        int   n;
        logic found;
        checks = 0;
        failures = 0;
        pulse_cnt = 0;
        dif.bus_addr     = 16'h0000;
        dif.bus_wdata    = 8'h00;
        dif.bus_write_en = 1'b0;
        dif.bus_read_en  = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", 32'(dif.dma_active), 32'd0);
        check("rst_src_req", 32'(dif.src_read_req), 32'd0);
        check("rst_oam_we", 32'(dif.oam_write_en), 32'd0);
        check("rst_oam_addr", 32'(dif.oam_addr), 32'd0);
        check("rst_oam_wdata", 32'(dif.oam_wdata), 32'd0);
        bus_read_check("rst_page", 16'hFF46, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(8'hC1, -1, 8'h00, 644);
        run_xfer(8'hC1, 79, 8'hC2, 968);
        run_xfer(8'hC1, 159, 8'hC3, 1288);
        run_xfer(8'hE3, -1, 8'h00, 644);
        run_xfer(8'h80, -1, 8'h00, 644);
        bus_read_check("page_80", 16'hFF46, 8'h80);
        bus_read_check("other_addr", 16'hFF45, 8'hFF);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        pulse_cnt = 0;
        push_expect(8'h12);
        bus_write(16'hFF46, 8'h12);
        found = 1'b0;
        n = 0;
        while (n < 1000 && !found) begin
            @(negedge clk);
            n++;
            if (dif.oam_write_en && dif.oam_addr == 8'd40) found = 1'b1;
        end
        check("mid_xfer_reached", 32'(found), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_active", 32'(dif.dma_active), 32'd0);
        check("abort_oam_we", 32'(dif.oam_write_en), 32'd0);
        @(posedge clk);
        #1;
        check("abort_active_clk", 32'(dif.dma_active), 32'd0);
        check("abort_src_req", 32'(dif.src_read_req), 32'd0);
        check("abort_oam_addr", 32'(dif.oam_addr), 32'd0);
        bus_read_check("abort_page", 16'hFF46, 8'h00);
        flush_expect();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_pulses", 32'(pulse_cnt), 32'd41);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
